// File: rtl/arb_defs_pkg.sv
// Shared definitions for the four-source bus arbiter: FSM encodings,
// widths and the one-hot helper used by both the picker and the top level.
package arb_defs_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      TURN  = 2'b10
   } arb_state_t;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin priority encoder: the search starts one past
// the previous owner and wraps upward, so the previous owner ranks last.
module rr_pick4
   import arb_defs_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   last,
   output logic [SEL_W-1:0]   winner,
   output logic               any
);

   logic [SEL_W-1:0] idx;

   // Walk from the lowest priority up so the highest-priority hit is written last.
   always_comb begin
      winner = last;
      idx    = '0;
      any    = |req;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = last + SEL_W'(i);
         if (req[idx]) winner = idx;
      end
   end

endmodule

// File: rtl/bus_arbiter_4.sv
// Round-robin owner sequencer for the shared internal data bus: drives the
// 4:1 mux select and a one-hot grant, with a turnaround cycle between owners.
//
//   state | meaning
//   IDLE  | no owner; pick a winner by round-robin when any req is set
//   GRANT | grant[last] held; release on req drop or on hold limit under contention
//   TURN  | single dead cycle, grant = 0, sel frozen
module bus_arbiter_4
   import arb_defs_pkg::*;
#(
   parameter int HOLD_MAX = 8
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [SEL_W-1:0]   sel,
   output logic               busy
);

   localparam bit         LIMITED  = (HOLD_MAX != 0);
   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

   arb_state_t       state;
   logic [SEL_W-1:0] last;
   logic [7:0]       hold_cnt;
   logic [SEL_W-1:0] winner;
   logic             any;
   logic             others;
   logic             release_now;

   rr_pick4 u_pick (
      .req    (req),
      .last   (last),
      .winner (winner),
      .any    (any)
   );

   assign others      = |(req & ~onehot(last));
   assign release_now = !req[last] || (LIMITED && (hold_cnt == HOLD_LIM) && others);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         sel      <= '0;
         busy     <= 1'b0;
         last     <= 2'd3;
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               grant <= '0;
               busy  <= 1'b0;
               if (any) begin
                  grant    <= onehot(winner);
                  sel      <= winner;
                  last     <= winner;
                  hold_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (release_now) begin
                  grant <= '0;
                  state <= TURN;
               end else if (hold_cnt != 8'hFF) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            TURN: begin
               grant <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               grant <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Bench for bus_arbiter_4: three instances (HOLD_MAX 0, 4, 8) share stimulus;
// a table, a rotation sequence and random traffic are checked against a model.
module tb_bus_arbiter_4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;

   logic [3:0] g  [3];
   logic [1:0] s  [3];
   logic       b  [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bus_arbiter_4 #(.HOLD_MAX(0)) dut0 (.clk(clk), .rst(rst), .req(req), .grant(g[0]), .sel(s[0]), .busy(b[0]));
   bus_arbiter_4 #(.HOLD_MAX(4)) dut4 (.clk(clk), .rst(rst), .req(req), .grant(g[1]), .sel(s[1]), .busy(b[1]));
   bus_arbiter_4                 dut8 (.clk(clk), .rst(rst), .req(req), .grant(g[2]), .sel(s[2]), .busy(b[2]));

   // Reference model: who owns the bus, how long it has held, and whether
   // we are in the dead cycle after a release.
   int hm     [3] = '{0, 4, 8};
   int m_own  [3];
   int m_dead [3];
   int m_last [3];
   int m_sel  [3];
   int m_ten  [3];

   task automatic model_update();
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            m_own[d] = -1; m_dead[d] = 0; m_last[d] = 3; m_sel[d] = 0; m_ten[d] = 0;
         end else if (m_dead[d] != 0) begin
            m_dead[d] = 0;
         end else if (m_own[d] >= 0) begin
            bit others;
            bit forced;
            others = (req & ~(4'b0001 << m_own[d])) != 4'b0000;
            forced = (hm[d] != 0) && (m_ten[d] == hm[d]) && others;
            if (!req[m_own[d]] || forced) begin
               m_own[d]  = -1;
               m_dead[d] = 1;
            end else begin
               m_ten[d] = m_ten[d] + 1;
            end
         end else if (req != 4'b0000) begin
            bit found;
            found = 0;
            for (int i = 1; i <= 4; i++) begin
               int c;
               c = (m_last[d] + i) % 4;
               if (!found && req[c]) begin
                  found    = 1;
                  m_own[d] = c;
               end
            end
            m_last[d] = m_own[d];
            m_sel[d]  = m_own[d];
            m_ten[d]  = 1;
         end
      end
   endtask

   task automatic chk(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
      end
   endtask

   task automatic check_models();
      for (int d = 0; d < 3; d++) begin
         logic [3:0] eg;
         logic       eb;
         eg = (m_own[d] >= 0) ? 4'(4'b0001 << m_own[d]) : 4'b0000;
         eb = (m_own[d] >= 0) || (m_dead[d] != 0);
         chk($sformatf("model_d%0d {grant,sel,busy}", hm[d]),
             int'({g[d], s[d], b[d]}), int'({eg, 2'(m_sel[d]), eb}));
         chk($sformatf("onehot0_d%0d", hm[d]), int'($onehot0(g[d])), 1);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_models();
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] grant;
      logic [1:0] sel;
      logic       busy;
   } vec_t;

   vec_t tbl[46];

   function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] eg,
                               input logic [1:0] es, input logic eb);
      vec_t v;
      v.rst = r; v.req = q; v.grant = eg; v.sel = es; v.busy = eb;
      return v;
   endfunction

   initial begin
      // Table for the HOLD_MAX=4 instance: reset, single requester, forced
      // release both ways, reset mid-grant, no-contention past the limit.
      tbl[0]  = mk(1, 4'hF, 4'h0, 2'd0, 0);
      tbl[1]  = mk(1, 4'hF, 4'h0, 2'd0, 0);
      tbl[2]  = mk(0, 4'hF, 4'h1, 2'd0, 1);
      tbl[3]  = mk(0, 4'h0, 4'h0, 2'd0, 1);
      tbl[4]  = mk(0, 4'h4, 4'h0, 2'd0, 0);
      tbl[5]  = mk(0, 4'h4, 4'h4, 2'd2, 1);
      tbl[6]  = mk(0, 4'h4, 4'h4, 2'd2, 1);
      tbl[7]  = mk(0, 4'h4, 4'h4, 2'd2, 1);
      tbl[8]  = mk(0, 4'h0, 4'h0, 2'd2, 1);
      tbl[9]  = mk(0, 4'h0, 4'h0, 2'd2, 0);
      tbl[10] = mk(0, 4'h0, 4'h0, 2'd2, 0);
      tbl[11] = mk(0, 4'h3, 4'h1, 2'd0, 1);
      tbl[12] = mk(0, 4'h3, 4'h1, 2'd0, 1);
      tbl[13] = mk(0, 4'h3, 4'h1, 2'd0, 1);
      tbl[14] = mk(0, 4'h3, 4'h1, 2'd0, 1);
      tbl[15] = mk(0, 4'h3, 4'h0, 2'd0, 1);
      tbl[16] = mk(0, 4'h3, 4'h0, 2'd0, 0);
      tbl[17] = mk(0, 4'h3, 4'h2, 2'd1, 1);
      tbl[18] = mk(0, 4'h3, 4'h2, 2'd1, 1);
      tbl[19] = mk(0, 4'h3, 4'h2, 2'd1, 1);
      tbl[20] = mk(0, 4'h3, 4'h2, 2'd1, 1);
      tbl[21] = mk(0, 4'h3, 4'h0, 2'd1, 1);
      tbl[22] = mk(0, 4'h3, 4'h0, 2'd1, 0);
      tbl[23] = mk(0, 4'h3, 4'h1, 2'd0, 1);
      tbl[24] = mk(0, 4'h3, 4'h1, 2'd0, 1);
      tbl[25] = mk(0, 4'h3, 4'h1, 2'd0, 1);
      tbl[26] = mk(0, 4'h3, 4'h1, 2'd0, 1);
      tbl[27] = mk(0, 4'h3, 4'h0, 2'd0, 1);
      tbl[28] = mk(0, 4'h3, 4'h0, 2'd0, 0);
      tbl[29] = mk(0, 4'h3, 4'h2, 2'd1, 1);
      tbl[30] = mk(1, 4'h3, 4'h0, 2'd0, 0);
      tbl[31] = mk(0, 4'h3, 4'h1, 2'd0, 1);
      tbl[32] = mk(0, 4'h8, 4'h0, 2'd0, 1);
      tbl[33] = mk(0, 4'h8, 4'h0, 2'd0, 0);
      for (int i = 34; i <= 43; i++) tbl[i] = mk(0, 4'h8, 4'h8, 2'd3, 1);
      tbl[44] = mk(0, 4'h0, 4'h0, 2'd3, 1);
      tbl[45] = mk(0, 4'h0, 4'h0, 2'd3, 0);

      for (int i = 0; i < 46; i++) begin
         rst = tbl[i].rst;
         req = tbl[i].req;
         step();
         chk($sformatf("vec%0d grant", i), int'(g[1]), int'(tbl[i].grant));
         chk($sformatf("vec%0d sel", i),   int'(s[1]), int'(tbl[i].sel));
         chk($sformatf("vec%0d busy", i),  int'(b[1]), int'(tbl[i].busy));
      end

      // Rotation on the unlimited instance: each owner drops for one cycle.
      rst = 1'b1; req = 4'hF;
      step();
      rst = 1'b0;
      step();
      chk("rot first grant", int'(g[0]), 1);
      for (int k = 1; k <= 4; k++) begin
         logic [3:0] prev;
         logic [3:0] nxt;
         prev = 4'(4'b0001 << ((k - 1) % 4));
         nxt  = 4'(4'b0001 << (k % 4));
         req = 4'hF & ~prev;
         step();
         chk($sformatf("rot%0d dead1 grant", k), int'(g[0]), 0);
         chk($sformatf("rot%0d dead1 busy", k), int'(b[0]), 1);
         req = 4'hF;
         step();
         chk($sformatf("rot%0d dead2 grant", k), int'(g[0]), 0);
         step();
         chk($sformatf("rot%0d grant", k), int'(g[0]), int'(nxt));
         chk($sformatf("rot%0d sel", k), int'(s[0]), k % 4);
      end

      // Random traffic with long-lived request patterns and occasional reset.
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
